// File: rtl/apb_slave_responder.sv
// APB completer backed by a word-addressed register store, with a fixed number
// of wait states and an error response for out-of-range or misaligned accesses.
module apb_slave_responder #(
  parameter int unsigned SLAVE_ID    = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic [2:0]  pselx,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic [15:0] xfer_count
);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             write_q;
  logic [31:0]      wdata_q;
  logic             bad_q;
  logic [3:0]       wait_q;
  logic [31:0]      prdata_q;
  logic             pready_q;
  logic             pslverr_q;
  logic [15:0]      count_q;
  logic [31:0]      mem_q [DEPTH];

  logic             sel;
  logic             setup;
  logic             respond;
  logic             bad_d;
  logic [31:0]      off;
  logic [IDX_W-1:0] idx_d;
  logic             rsp_bad;
  logic             rsp_write;
  logic [IDX_W-1:0] rsp_idx;
  logic             unused_sel;

  assign sel        = pselx[SLAVE_ID];
  assign unused_sel = ^pselx;

  assign off   = paddr - BASE_ADDR;
  assign idx_d = off[IDX_W+1:2];
  assign bad_d = (paddr < BASE_ADDR) || ((off >> 2) >= 32'(DEPTH)) || (paddr[1:0] != 2'b00);

  // A setup phase restarts the transfer from any state, so the response fields
  // come from the live bus then and from the latched copy during wait states.
  assign setup     = sel && !penable;
  assign rsp_bad   = setup ? bad_d  : bad_q;
  assign rsp_write = setup ? pwrite : write_q;
  assign rsp_idx   = setup ? idx_d  : idx_q;
  assign respond   = setup ? (WAIT_STATES == 0)
                           : (state_q == ACCESS && sel && penable && !pready_q && wait_q == 4'd1);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      bad_q     <= 1'b0;
      wait_q    <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      count_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i[IDX_W-1:0]] <= '0;
      end
    end else begin
      if (setup) begin
        state_q   <= ACCESS;
        idx_q     <= idx_d;
        write_q   <= pwrite;
        wdata_q   <= pwdata;
        bad_q     <= bad_d;
        wait_q    <= 4'(WAIT_STATES);
        pready_q  <= 1'b0;
        pslverr_q <= 1'b0;
      end else if (state_q == ACCESS) begin
        if (!sel || !penable) begin
          state_q   <= IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
        end else if (pready_q) begin
          if (write_q && !bad_q) begin
            mem_q[idx_q] <= wdata_q;
          end
          if (!bad_q) begin
            count_q <= count_q + 16'd1;
          end
          state_q   <= IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
        end else if (wait_q != 4'd0) begin
          wait_q <= wait_q - 4'd1;
        end
      end
      // Later assignments win, so this overrides the clears above when the
      // response is due in the same cycle.
      if (respond) begin
        pready_q  <= 1'b1;
        pslverr_q <= rsp_bad;
        if (!rsp_write) begin
          prdata_q <= rsp_bad ? '0 : mem_q[rsp_idx];
        end
      end
    end
  end

  assign prdata     = prdata_q;
  assign pready     = pready_q;
  assign pslverr    = pslverr_q;
  assign xfer_count = count_q;

endmodule
